// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: channel FSM encoding and board timing.
package key_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } chan_state_t;

    // 20 ms of stable input at the 50 MHz board clock.
    localparam int BOARD_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: input synchroniser, stability counter, STABLE/CHANGING FSM
// and registered rise/fall strobes.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic strobe_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    chan_state_t            state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= {SYNC_STAGES{RESET_LEVEL}};
            state_reg <= STABLE;
            cnt_reg   <= '0;
            level_reg <= RESET_LEVEL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // The counter restarts on any bounce back, so only an unbroken run of
    // DEBOUNCE_CYCLES differing samples reaches the terminal count.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            STABLE: begin
                cnt_next = '0;
                if (s != level_reg) begin
                    state_next = CHANGING;
                    cnt_next   = CNT_W'(1);
                end
            end
            CHANGING: begin
                if (s == level_reg) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TERMINAL) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                    level_next = s;
                    rise_next  = s;
                    fall_next  = ~s;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign level       = level_reg;
    assign rise        = rise_reg;
    assign fall        = fall_reg;
    // Exposed so the top can register key_any in the same cycle as the strobes.
    assign strobe_next = rise_next | fall_next;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: WIDTH independent channels plus a registered
// any-edge strobe aligned with the per-channel rise/fall pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_rise,
    output logic [WIDTH-1:0] key_fall,
    output logic             key_any
);

    logic [WIDTH-1:0] strobe_next_vec;
    logic             any_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            key_debounce_chan #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_LEVEL    (RESET_LEVEL)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw        (key_raw[gi]),
                .level      (key_level[gi]),
                .rise       (key_rise[gi]),
                .fall       (key_fall[gi]),
                .strobe_next(strobe_next_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_reg <= 1'b0;
        end else begin
            any_reg <= |strobe_next_vec;
        end
    end

    assign key_any = any_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] key_raw = '0;
    logic [W-1:0] key_level, key_rise, key_fall;
    logic         key_any;

    always #5 clk = ~clk;

    key_debounce #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (key_raw),
        .key_level(key_level),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .key_any  (key_any)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a key's new value is accepted once the value seen
    // SS edges late has differed from the accepted level for DC edges in a row.
    logic [W-1:0] m_level, m_rise, m_fall;
    logic         m_any;
    int           run_len [W];
    logic [W-1:0] hist [$];

    // Observation bookkeeping taken from the DUT outputs.
    int cyc;
    int rise_cnt [W];
    int fall_cnt [W];
    int rise_cyc [W];
    int fall_cyc [W];
    int last_strobe [W];
    int any_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_any   = 1'b0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_front('0);
        for (int i = 0; i < W; i++) begin
            run_len[i]     = 0;
            last_strobe[i] = -1000;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] d;
        hist.push_front(key_raw);
        d = hist[SS];
        while (hist.size() > SS) void'(hist.pop_back());
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (d[i] != m_level[i]) begin
                run_len[i]++;
                if (run_len[i] == DC) begin
                    m_level[i] = d[i];
                    if (d[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                    run_len[i] = 0;
                end
            end else begin
                run_len[i] = 0;
            end
        end
        m_any = |(m_rise | m_fall);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            rise_cyc[i] = -1;
            fall_cyc[i] = -1;
        end
        any_cnt = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("level", key_level, m_level);
        check("rise", key_rise, m_rise);
        check("fall", key_fall, m_fall);
        check("any", key_any, m_any);
        check("rise_fall_excl", key_rise & key_fall, '0);
        for (int i = 0; i < W; i++) begin
            if (key_rise[i] || key_fall[i]) begin
                if (cyc - last_strobe[i] < DC)
                    check("strobe_spacing", cyc - last_strobe[i], DC);
                last_strobe[i] = cyc;
            end
            if (key_rise[i]) begin
                rise_cnt[i]++;
                rise_cyc[i] = cyc;
            end
            if (key_fall[i]) begin
                fall_cnt[i]++;
                fall_cyc[i] = cyc;
            end
        end
        if (key_any) any_cnt++;
    endtask

    task automatic hold(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_level", key_level, '0);
        check("rst_rise", key_rise, '0);
        check("rst_fall", key_fall, '0);
        check("rst_any", key_any, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int step_cyc;
        int rem [W];

        cyc = 0;
        model_reset();
        clear_counts();
        do_reset();

        // Idle after reset: nothing moves.
        hold(50);
        check("idle_level", key_level, '0);
        check("idle_any_cnt", any_cnt, 0);
        $display("idle 50 cycles: level=%b any_cnt=%0d", key_level, any_cnt);

        // Clean step on channel 0.
        clear_counts();
        step_cyc   = cyc;
        key_raw[0] = 1'b1;
        hold(20);
        check("step_rise_cnt", rise_cnt[0], 1);
        check("step_latency", rise_cyc[0] - step_cyc, SS + DC);
        check("step_any_cnt", any_cnt, 1);
        $display("step ch0: latency=%0d rises=%0d", rise_cyc[0] - step_cyc, rise_cnt[0]);

        // Channel 1 bouncing with 3-cycle phases, then settling low.
        clear_counts();
        for (int p = 0; p < 8; p++) begin
            key_raw[1] = (p % 2 == 0);
            hold(3);
        end
        key_raw[1] = 1'b0;
        hold(20);
        check("bounce_rise_cnt", rise_cnt[1], 0);
        check("bounce_fall_cnt", fall_cnt[1], 0);
        check("bounce_level", key_level[1], 1'b0);
        $display("bounce ch1: rises=%0d falls=%0d", rise_cnt[1], fall_cnt[1]);

        // Channel 2: one cycle short of the threshold, then exactly enough.
        clear_counts();
        key_raw[2] = 1'b1;
        hold(7);
        key_raw[2] = 1'b0;
        hold(20);
        check("short_rise_cnt", rise_cnt[2], 0);
        key_raw[2] = 1'b1;
        hold(8);
        hold(20);
        check("thresh_rise_cnt", rise_cnt[2], 1);
        check("thresh_level", key_level[2], 1'b1);
        $display("threshold ch2: rises=%0d level=%b", rise_cnt[2], key_level[2]);

        // Channels 3 and 2 fall together.
        key_raw[3] = 1'b1;
        hold(20);
        clear_counts();
        key_raw[3:2] = 2'b00;
        hold(20);
        check("joint_fall2", fall_cnt[2], 1);
        check("joint_fall3", fall_cnt[3], 1);
        check("joint_same_cyc", fall_cyc[3] - fall_cyc[2], 0);
        check("joint_any_cnt", any_cnt, 1);
        $display("joint fall ch3/ch2: cycles %0d/%0d any_cnt=%0d", fall_cyc[3], fall_cyc[2], any_cnt);

        // Reset in the middle of a pending rise on channel 0.
        key_raw = '0;
        hold(20);
        key_raw[0] = 1'b1;
        hold(SS + 5);
        do_reset();
        clear_counts();
        step_cyc = cyc;
        hold(SS + DC - 1);
        check("post_rst_early", rise_cnt[0], 0);
        hold(10);
        check("post_rst_rise_cnt", rise_cnt[0], 1);
        check("post_rst_latency", rise_cyc[0] - step_cyc, SS + DC);
        $display("reset mid-count: latency=%0d rises=%0d", rise_cyc[0] - step_cyc, rise_cnt[0]);

        // Random bouncing on all channels against the model.
        for (int i = 0; i < W; i++) rem[i] = 0;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < W; i++) begin
                if (rem[i] == 0) begin
                    key_raw[i] = 1'($urandom_range(0, 1));
                    rem[i]     = $urandom_range(1, 14);
                end
                rem[i]--;
            end
            cycle();
        end
        $display("random phase done: final level=%b", key_level);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-conditioning stage placed directly upstream of the board-level LED/logic top.
- Takes raw asynchronous push-button/switch signals and synchronises them to clk.
- Debounces each channel independently.
- Delivers a clean level for each channel, plus one-cycle rise/fall strobes, to the consuming top module's 4-bit input.

Parameters:
- WIDTH, 4, number of independent key channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal range 2..4).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (20 ms at 50 MHz; must be >= 2).
- RESET_LEVEL, 0, idle/released level of the keys; applied to all synchroniser flops and key_level at reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- key_raw  input  WIDTH  raw asynchronous key/switch inputs.
- key_level  output  WIDTH  debounced level per channel; feeds the downstream top's in[].
- key_rise  output  WIDTH  one-cycle pulse when the debounced level goes 0->1.
- key_fall  output  WIDTH  one-cycle pulse when the debounced level goes 1->0.
- key_any  output  1  OR of all key_rise and key_fall bits in the same cycle (registered with them).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchroniser flops = RESET_LEVEL.
  - key_level = {WIDTH{RESET_LEVEL}}.
  - key_rise = 0, key_fall = 0, key_any = 0.
  - All counters = 0; every channel FSM enters STABLE.
- No edge strobe fires on reset release unless the input actually differs from RESET_LEVEL for the full debounce window.
- Synchroniser: key_raw[i] passes through SYNC_STAGES flops to give s[i]. No combinational path from key_raw to any output.
- Per-channel FSM, states STABLE and CHANGING:
  - STABLE: cnt = 0. If s[i] != key_level[i], go to CHANGING with cnt = 1.
  - CHANGING, s[i] == key_level[i] (bounce back): return to STABLE, cnt = 0, no strobe.
  - CHANGING, s[i] != key_level[i] and cnt == DEBOUNCE_CYCLES-1: on this edge key_level[i] <= s[i], assert the matching rise/fall bit for exactly this one cycle, cnt = 0, go to STABLE.
  - CHANGING, otherwise: cnt <= cnt + 1.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps, because it is cleared at terminal count.
- Latency: a clean step on key_raw appears on key_level exactly SYNC_STAGES + DEBOUNCE_CYCLES clk edges after the first edge that samples the new value. key_rise/key_fall are asserted in the same cycle that key_level changes.
- A bounce of any length shorter than DEBOUNCE_CYCLES produces no output change and no strobe.
- Channels are fully independent. Simultaneous transitions on several channels may strobe in the same cycle; key_any is then 1 for that single cycle.
- key_rise[i] and key_fall[i] are never both 1.
- At least DEBOUNCE_CYCLES cycles separate two successive strobes on the same channel.
- Reset mid-count: the pending transition is discarded, outputs return to reset values immediately, and no strobe is emitted on release.
- Input held constant forever: outputs stay constant and no strobes occur.

Decomposition:
- Shared package key_debounce_pkg:
  - Channel state encoding (STABLE = 1'b0, CHANGING = 1'b1).
  - Default debounce constant for the 50 MHz board clock.
- Natural sub-module: key_debounce_chan, one channel containing synchroniser, counter, FSM and edge registers, with ports clk, rst_n, raw, level, rise, fall.
- key_debounce instantiates WIDTH copies in a generate loop and registers key_any.

Test Plan (bench uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
- Reset release with key_raw=4'b0000 held for 50 cycles -> key_level=0000, no rise/fall/any pulses at any time.
- key_raw[0] steps 0->1 and is held -> key_level[0]=1 exactly 10 edges after the step is first sampled; key_rise[0]=1 for one cycle coincident with it; key_any=1 that same cycle.
- key_raw[1] toggles 1,0,1,0 with 3-cycle periods for 24 cycles, then settles at 0 -> key_level[1] stays 0 throughout, no strobes.
- key_raw[2] high 7 cycles then low (one short of the threshold) -> no change. Then held high 8 cycles -> key_level[2]=1 with a single key_rise[2].
- key_raw[3:2] both fall from 11 to 00 on the same edge -> key_fall[3] and key_fall[2] pulse together in one cycle, key_any=1 once.
- key_raw[0] held high, rst_n pulsed low at debounce count 5 -> key_level=0 immediately. After release with raw still high: rise at 10 edges post-release, none earlier.
